mux16_arbiter: RTL

Two-requester, round-robin arbiter sharing one 16-bit Mux16 datapath onto a single registered output bus. Each requester presents a word with a request; the arbiter selects a winner, steers the Mux16 select, captures the word into an output register, and acknowledges the winner. A burst limit bounds how long one requester may hold the bus while the other waits. It sits between two 16-bit producers, such as the CPU write port and a DMA/IO port, and a single downstream consumer.

---
 rtl/mux16_arbiter_pkg.sv | 17 +
 rtl/mux16_arbiter_if.sv | 26 ++
 rtl/mux16_arbiter_mux16.sv | 11 +
 rtl/mux16_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/mux16_arbiter_pkg.sv
// Shared encodings for the two-requester Mux16 arbiter: FSM states and owner identifiers.
package mux16_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwnA = 2'd1,
    StOwnB = 2'd2
  } state_e;

  typedef logic owner_t;

  localparam owner_t OwnerA = 1'b0;
  localparam owner_t OwnerB = 1'b1;

  localparam int unsigned CountW = 4;

endpackage

// File: rtl/mux16_arbiter_if.sv
// Producer/consumer bus around the arbiter: two request/data/ack channels and one output channel.
interface mux16_arbiter_if;

  logic        req_a;
  logic [15:0] data_a;
  logic        req_b;
  logic [15:0] data_b;
  logic        ack_a;
  logic        ack_b;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;

  // Arbiter side.
  modport slave (
    input  req_a, data_a, req_b, data_b, out_ready,
    output ack_a, ack_b, out, out_valid
  );

  // Producers and consumer side.
  modport master (
    output req_a, data_a, req_b, data_b, out_ready,
    input  ack_a, ack_b, out, out_valid
  );

endinterface

// File: rtl/mux16_arbiter_mux16.sv
// 16-bit two-way word multiplexer; sel_i=0 passes a_i, sel_i=1 passes b_i.
module mux16_arbiter_mux16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        sel_i,
  output logic [15:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mux16_arbiter.sv
// Round-robin arbiter with burst limit, steering two 16-bit producers through a shared Mux16
// into one registered output word.
module mux16_arbiter
  import mux16_arbiter_pkg::*;
#(
  parameter int unsigned BURST = 4
) (
  input logic             clk,
  input logic             reset,
  mux16_arbiter_if.slave  bus
);

  localparam logic [CountW-1:0] BurstCnt = CountW'(BURST);

  state_e              state_q, state_d;
  logic [CountW-1:0]   count_q, count_d;
  owner_t              last_q, last_d;
  logic [15:0]         out_q, out_d;
  logic                out_valid_q, out_valid_d;

  owner_t              winner;
  owner_t              cur_owner;
  logic                any_req;
  logic                at_burst;
  logic                load;
  logic [15:0]         mux_out;

  assign any_req   = bus.req_a | bus.req_b;
  assign at_burst  = (count_q == BurstCnt);
  assign cur_owner = (state_q == StOwnB) ? OwnerB : OwnerA;
  assign load      = any_req & (~out_valid_q | bus.out_ready) & ~reset;

  always_comb begin
    winner = OwnerA;
    if (bus.req_a && !bus.req_b) begin
      winner = OwnerA;
    end else if (bus.req_b && !bus.req_a) begin
      winner = OwnerB;
    end else if (bus.req_a && bus.req_b) begin
      unique case (state_q)
        StOwnA:  winner = at_burst ? OwnerB : OwnerA;
        StOwnB:  winner = at_burst ? OwnerA : OwnerB;
        default: winner = ~last_q;
      endcase
    end
  end

  mux16_arbiter_mux16 u_mux16 (
    .a_i   (bus.data_a),
    .b_i   (bus.data_b),
    .sel_i (winner == OwnerB),
    .y_o   (mux_out)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    last_d      = last_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    if (load) begin
      state_d = (winner == OwnerB) ? StOwnB : StOwnA;
      // Same owner continues unless it just hit the limit; a lone requester restarts at 1.
      if (state_q != StIdle && winner == cur_owner && !at_burst) begin
        count_d = count_q + 1'b1;
      end else begin
        count_d = 1;
      end
      last_d      = winner;
      out_d       = mux_out;
      out_valid_d = 1'b1;
    end else begin
      if (!any_req) begin
        state_d = StIdle;
      end
      if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      last_q      <= OwnerB;
      out_q       <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      last_q      <= last_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.ack_a     = load & (winner == OwnerA);
  assign bus.ack_b     = load & (winner == OwnerB);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule
